// File: rtl/imem_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect/halt control and
// the decode-side val/rdy delivery port.
interface imem_fetch_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned OccW = $clog2(DEPTH) + 1;

   logic            imemreq_val;
   logic [31:0]     imemreq_addr;
   logic [31:0]     imemresp_data;
   logic            redirect_val;
   logic [31:0]     redirect_pc;
   logic            halt;
   logic            inst_val;
   logic            inst_rdy;
   logic [31:0]     inst_pc;
   logic [31:0]     inst_data;
   logic [OccW-1:0] occupancy;

   modport master (
      output imemreq_val, imemreq_addr, inst_val, inst_pc, inst_data, occupancy,
      input  imemresp_data, redirect_val, redirect_pc, halt, inst_rdy
   );

   modport slave (
      input  imemreq_val, imemreq_addr, inst_val, inst_pc, inst_data, occupancy,
      output imemresp_data, redirect_val, redirect_pc, halt, inst_rdy
   );
endinterface

// File: rtl/imem_fetch_queue.sv
// Instruction-fetch front end: fetches from a combinational instruction memory into a
// small {pc, instruction} FIFO, with redirect-flush and halt support.
module imem_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input logic                 clk,
   input logic                 rst,
   imem_fetch_queue_if.master  bus_io
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned OccW = PtrW + 1;

   typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [OccW-1:0] count_q, count_d;
   logic [31:0]     pc_mem_q   [DEPTH];
   logic [31:0]     data_mem_q [DEPTH];
   logic            fetch, deq;

   // No path from inst_rdy into the request: a full queue waits one cycle to refill.
   assign fetch = (state_q == StRun) && (count_q < OccW'(DEPTH)) && !bus_io.redirect_val;
   assign deq   = (count_q != '0) && bus_io.inst_rdy;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus_io.redirect_val) begin
         state_d = StRun;
         pc_d    = bus_io.redirect_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         unique case (state_q)
            StBoot:   state_d = StRun;
            StRun:    if (bus_io.halt) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StBoot;
         endcase
         if (fetch) begin
            pc_d   = pc_q + PC_STEP;
            tail_d = tail_q + PtrW'(1);
         end
         if (deq) begin
            head_d = head_q + PtrW'(1);
         end
         count_d = count_q + OccW'(fetch) - OccW'(deq);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StBoot;
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else if (fetch) begin
         pc_mem_q[tail_q]   <= pc_q;
         data_mem_q[tail_q] <= bus_io.imemresp_data;
      end
   end

   assign bus_io.imemreq_val  = fetch;
   assign bus_io.imemreq_addr = pc_q;
   assign bus_io.inst_val     = (count_q != '0);
   assign bus_io.inst_pc      = pc_mem_q[head_q];
   assign bus_io.inst_data    = data_mem_q[head_q];
   assign bus_io.occupancy    = count_q;
endmodule

// File: tb/tb_imem_fetch_queue.sv
// Scoreboard bench for imem_fetch_queue: directed scenarios push expected fetch addresses
// and delivered {pc, inst} pairs; a negedge monitor pops and compares them.
module tb_imem_fetch_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] exp_fetch_q [$];
   logic [63:0] exp_deliv_q [$];

   imem_fetch_queue_if #(.DEPTH(4)) bus ();

   imem_fetch_queue #(
      .DEPTH(4),
      .RESET_PC(32'h0000_0000),
      .PC_STEP(32'd4)
   ) dut (
      .clk(clk),
      .rst(rst_n),
      .bus_io(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0000_0013;
         32'h0000_0004: mem_word = 32'h0050_0093;
         default:       mem_word = a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign bus.imemresp_data = mem_word(bus.imemreq_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every fetch and every delivery handshake must match the next expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.imemreq_val) begin
            if (exp_fetch_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fetch_extra: got addr %h expected no fetch", bus.imemreq_addr);
            end else begin
               chk("fetch_addr", {32'h0, bus.imemreq_addr}, {32'h0, exp_fetch_q.pop_front()});
            end
         end
         if (bus.inst_val && bus.inst_rdy) begin
            if (exp_deliv_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL deliv_extra: got pc %h expected no delivery", bus.inst_pc);
            end else begin
               chk("deliv_pc_inst", {bus.inst_pc, bus.inst_data}, exp_deliv_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_deliv(input logic [31:0] pc);
      exp_deliv_q.push_back({pc, mem_word(pc)});
   endtask

   // Called 1 time unit after a posedge: resets, audits leftovers, releases after one edge.
   task automatic begin_test(input logic rdy);
      rst_n = 1'b0;
      chk("leftover_fetch", 64'(exp_fetch_q.size()), 64'd0);
      chk("leftover_deliv", 64'(exp_deliv_q.size()), 64'd0);
      exp_fetch_q.delete();
      exp_deliv_q.delete();
      bus.redirect_val = 1'b0;
      bus.redirect_pc  = 32'h0;
      bus.halt         = 1'b0;
      bus.inst_rdy     = rdy;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.redirect_val = 1'b0;
      bus.redirect_pc  = 32'h0;
      bus.halt         = 1'b0;
      bus.inst_rdy     = 1'b1;
      #2;
      chk("rst_imemreq_val",  64'(bus.imemreq_val),  64'd0);
      chk("rst_imemreq_addr", 64'(bus.imemreq_addr), 64'h0);
      chk("rst_inst_val",     64'(bus.inst_val),     64'd0);
      chk("rst_inst_pc",      64'(bus.inst_pc),      64'h0);
      chk("rst_inst_data",    64'(bus.inst_data),    64'h0);
      chk("rst_occupancy",    64'(bus.occupancy),    64'd0);
      step();

      // Boot then straight-line fetch with decode always ready.
      begin_test(1'b1);
      exp_fetch_q.push_back(32'h0);
      exp_fetch_q.push_back(32'h4);
      exp_fetch_q.push_back(32'h8);
      push_deliv(32'h0);
      push_deliv(32'h4);
      @(negedge clk);
      chk("boot_no_fetch", 64'(bus.imemreq_val), 64'd0);
      repeat (3) @(negedge clk);
      step();

      // Fill to DEPTH with decode stalled, one dequeue, one-bubble refill.
      begin_test(1'b0);
      for (int a = 0; a <= 16; a += 4) exp_fetch_q.push_back(32'(a));
      push_deliv(32'h0);
      repeat (6) @(negedge clk);
      chk("full_no_fetch", 64'(bus.imemreq_val), 64'd0);
      chk("full_occ",      64'(bus.occupancy),   64'd4);
      step();
      bus.inst_rdy = 1'b1;
      step();
      bus.inst_rdy = 1'b0;
      @(negedge clk);
      chk("after_deq_occ", 64'(bus.occupancy), 64'd3);
      step();
      @(negedge clk);
      chk("refill_occ",      64'(bus.occupancy),   64'd4);
      chk("refill_no_fetch", 64'(bus.imemreq_val), 64'd0);
      step();

      // Redirect with three entries queued; same-cycle dequeue still consumes the head.
      begin_test(1'b0);
      exp_fetch_q.push_back(32'h0);
      exp_fetch_q.push_back(32'h4);
      exp_fetch_q.push_back(32'h8);
      exp_fetch_q.push_back(32'h100);
      exp_fetch_q.push_back(32'h104);
      push_deliv(32'h0);
      push_deliv(32'h100);
      repeat (4) step();
      bus.redirect_val = 1'b1;
      bus.redirect_pc  = 32'h100;
      bus.inst_rdy     = 1'b1;
      @(negedge clk);
      chk("pre_redirect_occ", 64'(bus.occupancy), 64'd3);
      step();
      bus.redirect_val = 1'b0;
      @(negedge clk);
      chk("post_redirect_occ",     64'(bus.occupancy), 64'd0);
      chk("post_redirect_invalid", 64'(bus.inst_val),  64'd0);
      step();
      @(negedge clk);
      step();

      // Redirect in BOOT to 0x20, one-cycle halt, drain, resume via redirect to 0x40.
      begin_test(1'b1);
      bus.redirect_val = 1'b1;
      bus.redirect_pc  = 32'h20;
      exp_fetch_q.push_back(32'h20);
      exp_fetch_q.push_back(32'h40);
      exp_fetch_q.push_back(32'h44);
      push_deliv(32'h20);
      push_deliv(32'h40);
      step();
      bus.redirect_val = 1'b0;
      bus.halt         = 1'b1;
      step();
      bus.halt = 1'b0;
      repeat (9) step();
      @(negedge clk);
      chk("halted_occ",      64'(bus.occupancy),   64'd0);
      chk("halted_no_fetch", 64'(bus.imemreq_val), 64'd0);
      step();
      bus.redirect_val = 1'b1;
      bus.redirect_pc  = 32'h40;
      step();
      bus.redirect_val = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      step();

      // PC wraps through 2^32.
      begin_test(1'b1);
      bus.redirect_val = 1'b1;
      bus.redirect_pc  = 32'hFFFF_FFF8;
      exp_fetch_q.push_back(32'hFFFF_FFF8);
      exp_fetch_q.push_back(32'hFFFF_FFFC);
      exp_fetch_q.push_back(32'h0000_0000);
      exp_fetch_q.push_back(32'h0000_0004);
      push_deliv(32'hFFFF_FFF8);
      push_deliv(32'hFFFF_FFFC);
      push_deliv(32'h0000_0000);
      step();
      bus.redirect_val = 1'b0;
      repeat (4) @(negedge clk);
      step();

      // Asynchronous reset in the middle of a cycle with two entries queued.
      begin_test(1'b0);
      exp_fetch_q.push_back(32'h0);
      exp_fetch_q.push_back(32'h4);
      exp_fetch_q.push_back(32'h8);
      repeat (4) @(negedge clk);
      chk("pre_async_occ", 64'(bus.occupancy), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_inst_val",  64'(bus.inst_val),     64'd0);
      chk("async_occ",       64'(bus.occupancy),    64'd0);
      chk("async_addr",      64'(bus.imemreq_addr), 64'h0);
      chk("async_req_val",   64'(bus.imemreq_val),  64'd0);
      chk("final_left_fetch", 64'(exp_fetch_q.size()), 64'd0);
      chk("final_left_deliv", 64'(exp_deliv_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
